// File: rtl/arm_lsm_seq_if.sv
// rtl/arm_lsm_seq_if.sv - single-beat memory port between the LDM/STM sequencer and memory
interface arm_lsm_seq_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/arm_lsm_seq.sv
// rtl/arm_lsm_seq.sv - LDM/STM sequencer over the register file and a single-beat memory port
module arm_lsm_seq (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         start,
   input  logic [31:0]  inst,
   input  logic [31:0]  rn_out,
   input  logic [31:0]  reg_out,
   output logic [3:0]   reg_idx,
   output logic         reg_we,
   output logic [31:0]  reg_wdata,
   output logic         busy,
   output logic         done,
   arm_lsm_seq_if.master mem
);

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_WB, ST_DONE} state_t;

   state_t      state;
   logic        p_q, u_q, w_q, l_q;
   logic [3:0]  rn_idx_q;
   logic [31:0] base_q;
   logic [15:0] list_q;
   logic [31:0] wb_val_q;
   logic        wb_en_q;
   logic [31:0] addr_q;
   logic        req_q;
   logic        we_q;
   logic [3:0]  idx_q;
   logic        done_q;

   logic [4:0]  n;
   logic [31:0] n4;
   logic [31:0] first_addr;
   logic [15:0] list_next;
   logic        ack_ok;
   logic        unused_inst;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
      return c;
   endfunction

   function automatic logic [3:0] lowest16(input logic [15:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
      return r;
   endfunction

   assign n         = popcount16(list_q);
   assign n4        = {25'd0, n, 2'b00};
   assign list_next = list_q & ~(16'd1 << idx_q);
   assign ack_ok    = req_q && mem.mem_ack;

   always_comb begin
      first_addr = base_q;
      case ({p_q, u_q})
         2'b01:   first_addr = base_q;
         2'b11:   first_addr = base_q + 32'd4;
         2'b00:   first_addr = base_q - n4 + 32'd4;
         default: first_addr = base_q - n4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= ST_IDLE;
         p_q      <= 1'b0;
         u_q      <= 1'b0;
         w_q      <= 1'b0;
         l_q      <= 1'b0;
         rn_idx_q <= '0;
         base_q   <= '0;
         list_q   <= '0;
         wb_val_q <= '0;
         wb_en_q  <= 1'b0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  p_q      <= inst[24];
                  u_q      <= inst[23];
                  w_q      <= inst[21];
                  l_q      <= inst[20];
                  rn_idx_q <= inst[19:16];
                  list_q   <= inst[15:0];
                  base_q   <= rn_out;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               addr_q   <= first_addr;
               wb_val_q <= u_q ? (base_q + n4) : (base_q - n4);
               // a loaded base register takes precedence over writeback
               wb_en_q  <= w_q && !(l_q && list_q[rn_idx_q]);
               if (n == 5'd0) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end else begin
                  state <= ST_XFER;
                  req_q <= 1'b1;
                  we_q  <= ~l_q;
                  idx_q <= lowest16(list_q);
               end
            end
            ST_XFER: begin
               if (ack_ok) begin
                  list_q <= list_next;
                  addr_q <= addr_q + 32'd4;
                  if (list_next == 16'd0) begin
                     req_q <= 1'b0;
                     we_q  <= 1'b0;
                     if (w_q) begin
                        state <= ST_WB;
                        idx_q <= rn_idx_q;
                     end else begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        idx_q  <= '0;
                     end
                  end else begin
                     idx_q <= lowest16(list_next);
                  end
               end
            end
            ST_WB: begin
               state  <= ST_DONE;
               done_q <= 1'b1;
               idx_q  <= '0;
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
               addr_q <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign reg_idx   = idx_q;
   assign reg_we    = (state == ST_XFER && l_q && ack_ok) || (state == ST_WB && wb_en_q);
   assign reg_wdata = (state == ST_WB) ? wb_val_q :
                      (state == ST_XFER && l_q) ? mem.mem_rdata : 32'd0;
   assign busy      = (state != ST_IDLE);
   assign done      = done_q;

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = {addr_q[31:2], 2'b00};
   assign mem.mem_wdata = reg_out;

   assign unused_inst = &{1'b0, inst[31:25], inst[22]};

endmodule

// File: tb/tb_arm_lsm_seq.sv
// tb/tb_arm_lsm_seq.sv - scoreboard bench for the LDM/STM sequencer
module tb_arm_lsm_seq;
   logic        clk = 1'b0;
   logic        rst_b;
   logic        start;
   logic [31:0] inst;
   logic [31:0] rn_out;
   logic [31:0] reg_out;
   logic [3:0]  reg_idx;
   logic        reg_we;
   logic [31:0] reg_wdata;
   logic        busy;
   logic        done;

   arm_lsm_seq_if mem_if();

   logic resp_ack  = 1'b0;
   logic stray_ack = 1'b0;
   int   ack_dly   = 0;
   int   wait_cnt  = 0;

   assign mem_if.mem_ack   = resp_ack | stray_ack;
   assign mem_if.mem_rdata = mem_if.mem_addr ^ 32'hDEAD_0000;
   assign reg_out          = 32'h5500_0000 | {28'd0, reg_idx};

   arm_lsm_seq dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .inst      (inst),
      .rn_out    (rn_out),
      .reg_out   (reg_out),
      .reg_idx   (reg_idx),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .busy      (busy),
      .done      (done),
      .mem       (mem_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  idx;
      logic [31:0] wdata;
      int          hold;
   } beat_t;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] data;
   } wr_t;

   beat_t beat_q[$];
   wr_t   wr_q[$];
   int    done_q[$];

   int n_cmp    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bad(input string name, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h, expected none", name, act);
   endtask

   task automatic pb(input logic [31:0] a, input logic we, input logic [3:0] idx,
                     input logic [31:0] wd, input int hold);
      beat_t b;
      b.addr = a; b.we = we; b.idx = idx; b.wdata = wd; b.hold = hold;
      beat_q.push_back(b);
   endtask

   task automatic pw(input logic [3:0] idx, input logic [31:0] data);
      wr_t w;
      w.idx = idx; w.data = data;
      wr_q.push_back(w);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " busy"},      {31'd0, busy}, 32'd0);
      chk({tag, " done"},      {31'd0, done}, 32'd0);
      chk({tag, " mem_req"},   {31'd0, mem_if.mem_req}, 32'd0);
      chk({tag, " mem_we"},    {31'd0, mem_if.mem_we}, 32'd0);
      chk({tag, " reg_we"},    {31'd0, reg_we}, 32'd0);
      chk({tag, " reg_idx"},   {28'd0, reg_idx}, 32'd0);
      chk({tag, " mem_addr"},  mem_if.mem_addr, 32'd0);
      chk({tag, " reg_wdata"}, reg_wdata, 32'd0);
   endtask

   // memory model: acks after ack_dly wait cycles of a held request
   always @(posedge clk) begin
      #1;
      if (mem_if.mem_req) begin
         if (wait_cnt >= ack_dly) begin
            resp_ack = 1'b1;
            wait_cnt = 0;
         end else begin
            resp_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(posedge clk) cyc++;

   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_we  = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [3:0]  prev_idx = '0;
   int          hold = 0;
   beat_t       mb;
   wr_t         mw;
   int          md;

   always @(negedge clk) begin
      if (mem_if.mem_req) begin
         if (prev_req && !prev_ack && mem_if.mem_addr == prev_addr &&
             reg_idx == prev_idx && mem_if.mem_we == prev_we)
            hold++;
         else
            hold = 1;
         if (mem_if.mem_ack) begin
            if (beat_q.size() == 0) begin
               bad("unexpected beat addr", mem_if.mem_addr);
            end else begin
               mb = beat_q.pop_front();
               chk("beat addr", mem_if.mem_addr, mb.addr);
               chk("beat we", {31'd0, mem_if.mem_we}, {31'd0, mb.we});
               chk("beat idx", {28'd0, reg_idx}, {28'd0, mb.idx});
               if (mb.we) chk("beat wdata", mem_if.mem_wdata, mb.wdata);
               chk("beat hold cycles", hold, mb.hold);
            end
         end
      end
      prev_req  = mem_if.mem_req;
      prev_ack  = mem_if.mem_ack;
      prev_addr = mem_if.mem_addr;
      prev_idx  = reg_idx;
      prev_we   = mem_if.mem_we;

      if (reg_we) begin
         if (wr_q.size() == 0) begin
            bad("unexpected reg write idx", {28'd0, reg_idx});
         end else begin
            mw = wr_q.pop_front();
            chk("write idx", {28'd0, reg_idx}, {28'd0, mw.idx});
            chk("write data", reg_wdata, mw.data);
         end
      end

      if (done) begin
         done_cnt++;
         if (done_q.size() == 0) begin
            bad("unexpected done at cycle", cyc);
         end else begin
            md = done_q.pop_front();
            chk("done cycle", cyc, md);
         end
      end
   end

   task automatic run_op(input logic [31:0] i, input logic [31:0] rn, input int dly, input int lat);
      int d0;
      int c;
      d0 = done_cnt;
      c  = 0;
      @(posedge clk); #1;
      ack_dly = dly;
      inst    = i;
      rn_out  = rn;
      start   = 1'b1;
      done_q.push_back(cyc + lat);
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cnt == d0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      if (done_cnt == d0) bad("done timeout", c);
   endtask

   initial begin
      rst_b  = 1'b0;
      start  = 1'b0;
      inst   = '0;
      rn_out = '0;
      #3;
      check_idle("reset");
      @(posedge clk); #1;
      rst_b = 1'b1;

      // LDMIA r0!,{r1,r2,r4}
      pb(32'h1000, 1'b0, 4'd1, 32'h0, 1); pw(4'd1, 32'hDEAD_1000);
      pb(32'h1004, 1'b0, 4'd2, 32'h0, 1); pw(4'd2, 32'hDEAD_1004);
      pb(32'h1008, 1'b0, 4'd4, 32'h0, 1); pw(4'd4, 32'hDEAD_1008);
      pw(4'd0, 32'h0000_100C);
      run_op(32'hE8B0_0016, 32'h1000, 0, 6);

      // STMDB r13!,{r4,r14}
      pb(32'h1FF8, 1'b1, 4'd4,  32'h5500_0004, 1);
      pb(32'h1FFC, 1'b1, 4'd14, 32'h5500_000E, 1);
      pw(4'd13, 32'h0000_1FF8);
      run_op(32'hE92D_4010, 32'h2000, 0, 5);

      // LDMIB r3,{r0} with a slow memory
      pb(32'h14, 1'b0, 4'd0, 32'h0, 4); pw(4'd0, 32'hDEAD_0014);
      run_op(32'hE993_0001, 32'h10, 3, 6);

      // LDMIA r2!,{r2,r5}: loaded base beats writeback
      pb(32'h40, 1'b0, 4'd2, 32'h0, 1); pw(4'd2, 32'hDEAD_0040);
      pb(32'h44, 1'b0, 4'd5, 32'h0, 1); pw(4'd5, 32'hDEAD_0044);
      run_op(32'hE8B2_0024, 32'h40, 0, 5);

      // empty list with writeback, stray acks throughout
      stray_ack = 1'b1;
      run_op(32'hE8B7_0000, 32'h80, 0, 2);
      stray_ack = 1'b0;

      // STMDA r1,{r0,r3}
      pb(32'hFC,  1'b1, 4'd0, 32'h5500_0000, 1);
      pb(32'h100, 1'b1, 4'd3, 32'h5500_0003, 1);
      run_op(32'hE801_0009, 32'h100, 0, 4);

      // STMDB r1,{r0,r1,r2} wrapping below zero
      pb(32'hFFFF_FFF8, 1'b1, 4'd0, 32'h5500_0000, 1);
      pb(32'hFFFF_FFFC, 1'b1, 4'd1, 32'h5500_0001, 1);
      pb(32'h0000_0000, 1'b1, 4'd2, 32'h5500_0002, 1);
      run_op(32'hE901_0007, 32'h4, 0, 5);

      // LDMIA r0,{r0-r15}: full 16-register list
      for (int k = 0; k < 16; k++) begin
         pb(32'h200 + 32'(4 * k), 1'b0, 4'(k), 32'h0, 1);
         pw(4'(k), 32'hDEAD_0200 + 32'(4 * k));
      end
      run_op(32'hE890_FFFF, 32'h200, 0, 18);

      // repeated start while busy, then reset during the second beat
      pb(32'h1000, 1'b0, 4'd1, 32'h0, 2); pw(4'd1, 32'hDEAD_1000);
      @(posedge clk); #1;
      ack_dly = 1;
      inst    = 32'hE8B0_0016;
      rn_out  = 32'h1000;
      start   = 1'b1;
      @(posedge clk); #1;
      inst    = 32'hE8B0_FFFF;
      rn_out  = 32'h3000;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_b = 1'b0;
      #1;
      check_idle("async reset");
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("post-reset busy", {31'd0, busy}, 32'd0);

      pb(32'h14, 1'b0, 4'd0, 32'h0, 4); pw(4'd0, 32'hDEAD_0014);
      run_op(32'hE993_0001, 32'h10, 3, 6);

      repeat (3) @(posedge clk);
      chk("beat queue drained", beat_q.size(), 32'd0);
      chk("write queue drained", wr_q.size(), 32'd0);
      chk("done queue drained", done_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/arm_lsm_seq.md
ARM_LSM_SEQ -- requirements
Module: arm_lsm_seq

Sequences load/store-multiple (LDM/STM) instructions over the register file and a single-beat memory port. `arm_decode` leaves these instructions undecoded.

Interface
REQ-001 clk  in  1  system clock; all state changes on the rising edge.
REQ-002 rst_b  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  one-cycle request to begin; asserted only when cond_pass=1 and inst[27:25]=3'b100.
REQ-004 inst  in  32  LDM/STM instruction; sampled only on an accepted start. Fields used: P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0].
REQ-005 rn_out  in  32  base register value; sampled with inst.
REQ-006 reg_out  in  32  register-file read data for reg_idx; used for STM store data.
REQ-007 reg_idx  out  4  register-file index currently being transferred.
REQ-008 reg_we  out  1  register-file write enable (LDM load data, or base writeback).
REQ-009 reg_wdata  out  32  register-file write data.
REQ-010 mem_req  out  1  memory request valid.
REQ-011 mem_we  out  1  1 = store, 0 = load; valid while mem_req=1.
REQ-012 mem_addr  out  32  word address; bits [1:0] always 0.
REQ-013 mem_wdata  out  32  store data, equal to reg_out.
REQ-014 mem_ack  in  1  memory completes the current beat in this cycle.
REQ-015 mem_rdata  in  32  load data; valid when mem_ack=1.
REQ-016 busy  out  1  sequencer not in IDLE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, XFER, WB and DONE.
REQ-019 IDLE SHALL accept start, latch inst and rn_out, and move to SETUP; start SHALL be ignored in every other state.
REQ-020 SETUP (1 cycle) SHALL compute n = popcount(list) as 5 bits, range 0..16, and compute the first address from the latched base:
- IA (P=0,U=1): Rn
- IB (P=1,U=1): Rn+4
- DA (P=0,U=0): Rn-4n+4
- DB (P=1,U=0): Rn-4n
All arithmetic is 32-bit modulo 2^32.
REQ-021 If n=0, SETUP SHALL go directly to DONE: no memory beats and no writeback.
REQ-022 Registers SHALL be transferred lowest index first at ascending addresses, incrementing by 4 per beat.
REQ-023 In XFER, mem_req SHALL stay 1 with mem_addr, mem_we, reg_idx and mem_wdata held stable until mem_ack=1.
REQ-024 On the mem_ack=1 cycle:
- for L=1, reg_we=1 and reg_wdata=mem_rdata to reg_idx in that same cycle;
- the serviced bit SHALL be cleared from the working list;
- the next beat SHALL begin the following cycle, with mem_req allowed to stay 1.
REQ-025 After the last ack, the FSM SHALL go to WB if W=1, otherwise to DONE.
REQ-026 WB (1 cycle) SHALL write reg_idx=Rn and reg_wdata=Rn+4n (U=1) or Rn-4n (U=0), with reg_we=1.
REQ-027 WB SHALL be suppressed (reg_we=0) when L=1 and Rn is in the list; the loaded value wins.
REQ-028 DONE SHALL assert done=1 for exactly 1 cycle, then return to IDLE.
REQ-029 reg_we SHALL be 0 in all cases other than those in REQ-024 and REQ-026, including throughout STM.
REQ-030 mem_req SHALL be 0 outside XFER.
REQ-031 busy SHALL be 1 in SETUP, XFER, WB and DONE.
REQ-032 A mem_ack received while mem_req=0 SHALL be ignored.
REQ-033 Latency SHALL be 1 (SETUP) + sum of beat cycles + W + 1 (DONE) cycles after start, with a beat being 1 cycle when ack is immediate.

Reset
REQ-034 rst_b=0 SHALL immediately force IDLE with busy=0, done=0, mem_req=0, mem_we=0, reg_we=0, reg_idx=0, mem_addr=0, reg_wdata=0 and the working list cleared.
REQ-035 Reset mid-transfer SHALL abandon the instruction; no further beat or writeback SHALL occur after release.
REQ-036 After reset release, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-037 LDMIA r0!,{r1,r2,r4} with r0=0x1000 and ack every cycle → beats 0x1000/r1, 0x1004/r2, 0x1008/r4; WB r0=0x100C; done 6 cycles after start.
REQ-038 STMDB r13!,{r4,r14} with r13=0x2000 → stores at 0x1FF8 (r4) and 0x1FFC (r14); WB r13=0x1FF8; reg_we never set for r4 or r14.
REQ-039 LDMIB r3,{r0} with r3=0x10, W=0, and ack delayed 3 cycles → mem_addr=0x14 held stable 4 cycles; r0 written once; no WB.
REQ-040 LDMIA r2!,{r2,r5} with r2=0x40 → r2 takes the loaded data from 0x40; WB suppressed.
REQ-041 Empty list with W=1 → no mem_req; done exactly 2 cycles after start; reg_we never set.
REQ-042 start repeated while busy, and rst_b low during the second beat → the extra start is ignored; outputs clear asynchronously; no beat or WB after release; a new start is accepted normally.
